mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the core's single SRAM-like memory port between the IF-stage instruction fetch and the MEM-stage load/store.
- Uses a req/addr_ok/data_ok handshake on both sides, with one transaction outstanding at a time.
- Data requests have priority, bounded by an anti-starvation counter for fetch.
- Supports cancelling an in-flight fetch on exception/eret flush.

Parameters:
STARVE_MAX, 4, consecutive lost fetch arbitrations before fetch is force-granted once; 0 = pure data priority
CNT_W, 3, width of starvation counter; must hold STARVE_MAX

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-low
inst_req  in  1  fetch request, held until inst_addr_ok
inst_addr  in  32  fetch address
inst_cancel  in  1  discard current/pending fetch (IF flush)
inst_addr_ok  out  1  fetch address accepted by memory
inst_data_ok  out  1  fetch data valid
inst_rdata  out  32  fetch data
data_req  in  1  load/store request, held until data_addr_ok
data_wr  in  1  1 = store
data_wstrb  in  4  store byte enables
data_addr  in  32  load/store address
data_wdata  in  32  store data
data_addr_ok  out  1  data address accepted
data_data_ok  out  1  load data valid / store complete
data_rdata  out  32  load data
mem_req  out  1  request to memory
mem_wr  out  1  write
mem_wstrb  out  4  byte enables
mem_addr  out  32  address
mem_wdata  out  32  write data
mem_addr_ok  in  1  memory accepted request
mem_data_ok  in  1  memory response
mem_rdata  in  32  memory read data
busy  out  1  transaction in progress

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE, grant=DATA, starve_cnt=0, drop=0.
  - All registered request fields are cleared to 0.
  - Every output is 0 in the following cycle.
- Reset mid-transaction abandons the transaction. Any late mem_data_ok is ignored.
- States: IDLE, REQ, RESP.
- IDLE:
  - Outputs are quiet; busy=0.
  - If a req is present, pick grant, latch that requester's addr/wr/wstrb/wdata, go to REQ.
  - Inst grants latch wr=0 and wstrb=0.
  - Grant rule:
    - Data only -> DATA; inst only -> INST.
    - Both requesting -> DATA, unless STARVE_MAX!=0 and starve_cnt==STARVE_MAX, then INST.
  - Counter rule:
    - Both requesting and DATA granted -> starve_cnt+1, saturating at STARVE_MAX.
    - Any INST grant -> starve_cnt=0.
  - mem_data_ok arriving in IDLE is discarded.
- REQ:
  - mem_req=1; mem_* are driven from the latched registers.
  - Latency: first mem_req one cycle after the requester's req is sampled.
  - Granted requester's addr_ok = mem_addr_ok, combinational, same cycle. The other requester's addr_ok=0.
  - On mem_addr_ok -> RESP.
- RESP:
  - mem_req=0. On mem_data_ok -> IDLE.
  - Granted requester's data_ok = mem_data_ok. rdata passes mem_rdata through combinationally.
  - Non-granted rdata holds 0.
  - Stores complete with data_ok; rdata is don't-care, driven to mem_rdata.
- Throughput: min 3 cycles per transaction (IDLE, REQ, RESP with immediate acks). No back-to-back issue from RESP.
- busy=1 in REQ and RESP.
- Cancel (only affects INST grants; ignored when grant=DATA or in IDLE):
  - REQ with inst_cancel=1 and mem_addr_ok=0:
    - Abort to IDLE; mem_req drops next cycle.
    - No addr_ok and no data_ok are given.
  - REQ with inst_cancel=1 and mem_addr_ok=1:
    - inst_addr_ok still pulses.
    - Go to RESP with drop=1.
  - RESP with inst_cancel=1, or drop=1:
    - inst_data_ok is suppressed, including a mem_data_ok in the same cycle as the cancel.
    - The transaction still drains to IDLE.
  - drop clears on entry to IDLE.
- inst_req arriving during a data transaction waits. Its addr is sampled only in IDLE. Requesters must hold req/addr stable until addr_ok.

Test Plan:
1. Reset with rst=0 for 2 cycles while mem_data_ok=1 -> all outputs 0, busy=0, no data_ok.
2. Single load: data_req, data_addr=0x8000_0010, memory acks addr 1 cycle and data 2 cycles later with 0xDEADBEEF -> mem_req high exactly 1 cycle (REQ); data_data_ok 1 cycle with data_rdata=0xDEADBEEF; inst_data_ok stays 0.
3. Store: data_wr=1, wstrb=4'b0011, wdata=0x1234_5678 -> mem_wr=1, mem_wstrb=0011, mem_wdata=0x1234_5678; data_data_ok on mem_data_ok.
4. Starvation: inst_req and data_req both held continuously, STARVE_MAX=4 -> grant sequence D,D,D,D,I,D,D,D,D,I.
5. Cancel before accept: inst grant, mem_addr_ok=0, inst_cancel=1 -> IDLE next cycle; no inst_addr_ok or inst_data_ok; a pending data_req is served next.
6. Cancel after accept: inst_addr_ok pulses, then inst_cancel=1 in RESP, mem_data_ok with 0xAAAA_5555 -> inst_data_ok stays 0; busy drops after mem_data_ok.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and load/store, one transaction in flight.
// Latency: mem_req one cycle after req is sampled; backpressure: requesters hold req until addr_ok.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_cancel,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  state_t           state, state_nxt;
  logic             grant_inst, grant_inst_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
  logic             drop, drop_nxt;
  logic [31:0]      lat_addr, lat_addr_nxt;
  logic             lat_wr, lat_wr_nxt;
  logic [3:0]       lat_wstrb, lat_wstrb_nxt;
  logic [31:0]      lat_wdata, lat_wdata_nxt;
  logic             pick_inst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      grant_inst <= 1'b0;
      starve_cnt <= '0;
      drop       <= 1'b0;
      lat_addr   <= '0;
      lat_wr     <= 1'b0;
      lat_wstrb  <= '0;
      lat_wdata  <= '0;
    end else begin
      state      <= state_nxt;
      grant_inst <= grant_inst_nxt;
      starve_cnt <= starve_cnt_nxt;
      drop       <= drop_nxt;
      lat_addr   <= lat_addr_nxt;
      lat_wr     <= lat_wr_nxt;
      lat_wstrb  <= lat_wstrb_nxt;
      lat_wdata  <= lat_wdata_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_inst_nxt = grant_inst;
    starve_cnt_nxt = starve_cnt;
    drop_nxt       = drop;
    lat_addr_nxt   = lat_addr;
    lat_wr_nxt     = lat_wr;
    lat_wstrb_nxt  = lat_wstrb;
    lat_wdata_nxt  = lat_wdata;
    pick_inst      = 1'b0;
    inst_addr_ok   = 1'b0;
    inst_data_ok   = 1'b0;
    inst_rdata     = '0;
    data_addr_ok   = 1'b0;
    data_data_ok   = 1'b0;
    data_rdata     = '0;
    mem_req        = 1'b0;
    mem_wr         = 1'b0;
    mem_wstrb      = '0;
    mem_addr       = '0;
    mem_wdata      = '0;
    busy           = 1'b0;

    case (state)
      IDLE: begin
        if (inst_req || data_req) begin
          // Fetch wins a contested slot only after STARVE_MAX consecutive losses
          pick_inst = inst_req && (!data_req || (STARVE_MAX != 0 && starve_cnt == STARVE_LIM));
          grant_inst_nxt = pick_inst;
          state_nxt      = REQ;
          drop_nxt       = 1'b0;
          if (pick_inst) begin
            lat_addr_nxt   = inst_addr;
            lat_wr_nxt     = 1'b0;
            lat_wstrb_nxt  = '0;
            lat_wdata_nxt  = '0;
            starve_cnt_nxt = '0;
          end else begin
            lat_addr_nxt  = data_addr;
            lat_wr_nxt    = data_wr;
            lat_wstrb_nxt = data_wstrb;
            lat_wdata_nxt = data_wdata;
            if (inst_req && starve_cnt != STARVE_LIM)
              starve_cnt_nxt = starve_cnt + CNT_W'(1);
          end
        end
      end

      REQ: begin
        busy         = 1'b1;
        mem_req      = 1'b1;
        mem_wr       = lat_wr;
        mem_wstrb    = lat_wstrb;
        mem_addr     = lat_addr;
        mem_wdata    = lat_wdata;
        inst_addr_ok = grant_inst && mem_addr_ok;
        data_addr_ok = !grant_inst && mem_addr_ok;
        if (grant_inst && inst_cancel && !mem_addr_ok) begin
          state_nxt = IDLE;
          drop_nxt  = 1'b0;
        end else if (mem_addr_ok) begin
          state_nxt = RESP;
          drop_nxt  = grant_inst && inst_cancel;
        end
      end

      RESP: begin
        busy = 1'b1;
        if (grant_inst) begin
          inst_rdata   = mem_rdata;
          inst_data_ok = mem_data_ok && !drop && !inst_cancel;
          drop_nxt     = drop || inst_cancel;
        end else begin
          data_rdata   = mem_rdata;
          data_data_ok = mem_data_ok;
        end
        if (mem_data_ok) begin
          state_nxt = IDLE;
          drop_nxt  = 1'b0;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, starvation sequence, randomized run against a transaction model.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_cancel, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, busy;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct packed {
    logic rst; logic ireq; logic [31:0] iaddr; logic icancel;
    logic dreq; logic dwr; logic [3:0] dwstrb; logic [31:0] daddr; logic [31:0] dwdata;
    logic maok; logic mdok; logic [31:0] mrdata;
  } in_t;

  typedef struct packed {
    logic busy; logic mreq; logic mwr; logic [3:0] mwstrb; logic [31:0] maddr; logic [31:0] mwdata;
    logic iaok; logic idok; logic [31:0] irdata; logic daok; logic ddok; logic [31:0] drdata;
  } out_t;

  typedef struct { string name; bit chk; in_t i; out_t o; } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic in_t iv(logic [31:0] r, logic [31:0] ir, logic [31:0] ia, logic [31:0] ic,
                             logic [31:0] dr, logic [31:0] dw, logic [31:0] ws, logic [31:0] da,
                             logic [31:0] wd, logic [31:0] aok, logic [31:0] dok, logic [31:0] rd);
    in_t v;
    v.rst = r[0]; v.ireq = ir[0]; v.iaddr = ia; v.icancel = ic[0];
    v.dreq = dr[0]; v.dwr = dw[0]; v.dwstrb = ws[3:0]; v.daddr = da; v.dwdata = wd;
    v.maok = aok[0]; v.mdok = dok[0]; v.mrdata = rd;
    return v;
  endfunction

  function automatic out_t ov(logic [31:0] b, logic [31:0] mr, logic [31:0] mw, logic [31:0] ms,
                              logic [31:0] ma, logic [31:0] md, logic [31:0] ia, logic [31:0] id,
                              logic [31:0] ird, logic [31:0] da, logic [31:0] dd, logic [31:0] drd);
    out_t o;
    o.busy = b[0]; o.mreq = mr[0]; o.mwr = mw[0]; o.mwstrb = ms[3:0]; o.maddr = ma; o.mwdata = md;
    o.iaok = ia[0]; o.idok = id[0]; o.irdata = ird; o.daok = da[0]; o.ddok = dd[0]; o.drdata = drd;
    return o;
  endfunction

  task automatic add(input string n, input bit c, input in_t i, input out_t o);
    vec_t v;
    v.name = n; v.chk = c; v.i = i; v.o = o;
    vecs.push_back(v);
  endtask

  task automatic apply(input in_t v);
    rst = v.rst; inst_req = v.ireq; inst_addr = v.iaddr; inst_cancel = v.icancel;
    data_req = v.dreq; data_wr = v.dwr; data_wstrb = v.dwstrb; data_addr = v.daddr;
    data_wdata = v.dwdata; mem_addr_ok = v.maok; mem_data_ok = v.mdok; mem_rdata = v.mrdata;
  endtask

  function automatic out_t sample();
    return {busy, mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
            inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata};
  endfunction

  // While waiting for the response the memory command fields carry no meaning.
  function automatic out_t care(out_t e);
    out_t m;
    m = '1;
    if (e.busy && !e.mreq) begin
      m.mwr = 1'b0; m.mwstrb = '0; m.maddr = '0; m.mwdata = '0;
    end
    return m;
  endfunction

  task automatic check(input string nm, input out_t exp);
    out_t got, m;
    got = sample();
    m = care(exp);
    n_cmp++;
    if (((got ^ exp) & m) !== '0) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  // Transaction-level reference: one in-flight record plus the history of arbitration outcomes.
  bit          t_vld, t_inst, t_acc, t_drop, t_wr;
  logic [3:0]  t_wstrb;
  logic [31:0] t_addr, t_wdata;
  bit          hist[$];   // 1 = fetch granted, 0 = fetch lost a contested slot

  function automatic bit fetch_starved();
    int n = 0;
    for (int k = hist.size() - 1; k >= 0; k--) begin
      if (hist[k]) break;
      n++;
    end
    return (STARVE_MAX != 0) && (n >= STARVE_MAX);
  endfunction

  localparam logic [31:0] DA = 32'h8000_0010, SA = 32'h8000_0020, DB = 32'h8000_0030;
  localparam logic [31:0] DC = 32'h8000_0040, IA0 = 32'hBFC0_0000, IA1 = 32'hBFC0_0004;
  localparam logic [31:0] IA2 = 32'hBFC0_0008, IA3 = 32'hBFC0_000C, IA4 = 32'hBFC0_0010;

  initial begin
    bit   exp_inst[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int   got_n;
    bit   ih, dh, cancel, maok, mdok;
    logic [31:0] ia, da, dwd, rd;
    logic dw;
    logic [3:0] dws;
    bit   pick;
    out_t exp;

    apply(iv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    //   name        chk  rst ireq iaddr icnl dreq dwr ws daddr wdata aok dok rdata
    add("rst_a",     0, iv(0, 0, 0,   0, 0, 0, 0, 0,  0,            0, 1, 0), '0);
    add("rst_b",     1, iv(0, 0, 0,   0, 0, 0, 0, 0,  0,            1, 1, 32'hFFFF_FFFF), '0);
    add("rst_rel",   1, iv(1, 0, 0,   0, 0, 0, 0, 0,  0,            1, 1, 32'hFFFF_FFFF), '0);
    add("ld_idle",   1, iv(1, 0, 0,   0, 1, 0, 0, DA, 0,            0, 0, 0), '0);
    add("ld_req",    1, iv(1, 0, 0,   0, 1, 0, 0, DA, 0,            1, 0, 0),
                        ov(1, 1, 0, 0, DA, 0, 0, 0, 0, 1, 0, 0));
    add("ld_wait",   1, iv(1, 0, 0,   0, 0, 0, 0, 0,  0,            0, 0, 32'h0BAD_F00D),
                        ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0BAD_F00D));
    add("ld_resp",   1, iv(1, 0, 0,   0, 0, 0, 0, 0,  0,            0, 1, 32'hDEAD_BEEF),
                        ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF));
    add("ld_done",   1, iv(1, 0, 0,   0, 0, 0, 0, 0,  0,            0, 0, 32'hDEAD_BEEF), '0);
    add("st_idle",   1, iv(1, 0, 0,   0, 1, 1, 3, SA, 32'h1234_5678, 0, 0, 0), '0);
    add("st_req",    1, iv(1, 0, 0,   0, 1, 1, 3, SA, 32'h1234_5678, 1, 0, 0),
                        ov(1, 1, 1, 3, SA, 32'h1234_5678, 0, 0, 0, 1, 0, 0));
    add("st_resp",   1, iv(1, 0, 0,   0, 0, 0, 0, 0,  0,            0, 1, 32'h55),
                        ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55));
    add("cb_idle",   1, iv(1, 1, IA0, 0, 0, 0, 0, 0,  0,            0, 0, 0), '0);
    add("cb_cancel", 1, iv(1, 1, IA0, 1, 1, 0, 0, DB, 0,            0, 0, 0),
                        ov(1, 1, 0, 0, IA0, 0, 0, 0, 0, 0, 0, 0));
    add("cb_abort",  1, iv(1, 0, 0,   0, 1, 0, 0, DB, 0,            0, 1, 32'h66), '0);
    add("cb_dreq",   1, iv(1, 0, 0,   0, 1, 0, 0, DB, 0,            1, 0, 0),
                        ov(1, 1, 0, 0, DB, 0, 0, 0, 0, 1, 0, 0));
    add("cb_dresp",  1, iv(1, 0, 0,   0, 0, 0, 0, 0,  0,            0, 1, 32'h77),
                        ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77));
    add("ca_idle",   1, iv(1, 1, IA1, 0, 0, 0, 0, 0,  0,            0, 0, 0), '0);
    add("ca_aok",    1, iv(1, 1, IA1, 0, 0, 0, 0, 0,  0,            1, 0, 0),
                        ov(1, 1, 0, 0, IA1, 0, 1, 0, 0, 0, 0, 0));
    add("ca_cancel", 1, iv(1, 0, 0,   1, 0, 0, 0, 0,  0,            0, 0, 32'h1),
                        ov(1, 0, 0, 0, 0, 0, 0, 0, 32'h1, 0, 0, 0));
    add("ca_drain",  1, iv(1, 0, 0,   0, 0, 0, 0, 0,  0,            0, 1, 32'hAAAA_5555),
                        ov(1, 0, 0, 0, 0, 0, 0, 0, 32'hAAAA_5555, 0, 0, 0));
    add("ca_idle2",  1, iv(1, 0, 0,   0, 0, 0, 0, 0,  0,            0, 0, 0), '0);
    add("cx_idle",   1, iv(1, 1, IA2, 0, 0, 0, 0, 0,  0,            0, 0, 0), '0);
    add("cx_both",   1, iv(1, 1, IA2, 1, 0, 0, 0, 0,  0,            1, 0, 0),
                        ov(1, 1, 0, 0, IA2, 0, 1, 0, 0, 0, 0, 0));
    add("cx_drain",  1, iv(1, 0, 0,   0, 0, 0, 0, 0,  0,            0, 1, 32'h1234),
                        ov(1, 0, 0, 0, 0, 0, 0, 0, 32'h1234, 0, 0, 0));
    add("cs_idle",   1, iv(1, 1, IA3, 0, 0, 0, 0, 0,  0,            0, 0, 0), '0);
    add("cs_aok",    1, iv(1, 1, IA3, 0, 0, 0, 0, 0,  0,            1, 0, 0),
                        ov(1, 1, 0, 0, IA3, 0, 1, 0, 0, 0, 0, 0));
    add("cs_same",   1, iv(1, 0, 0,   1, 0, 0, 0, 0,  0,            0, 1, 32'h99),
                        ov(1, 0, 0, 0, 0, 0, 0, 0, 32'h99, 0, 0, 0));
    add("if_idle",   1, iv(1, 1, IA4, 0, 0, 0, 0, 0,  0,            0, 0, 0), '0);
    add("if_aok",    1, iv(1, 1, IA4, 0, 0, 0, 0, 0,  0,            1, 0, 0),
                        ov(1, 1, 0, 0, IA4, 0, 1, 0, 0, 0, 0, 0));
    add("if_resp",   1, iv(1, 0, 0,   0, 0, 0, 0, 0,  0,            0, 1, 32'h3C00_0001),
                        ov(1, 0, 0, 0, 0, 0, 0, 1, 32'h3C00_0001, 0, 0, 0));
    add("if_done",   1, iv(1, 0, 0,   0, 0, 0, 0, 0,  0,            0, 1, 0), '0);
    add("rm_idle",   1, iv(1, 0, 0,   0, 1, 0, 0, DC, 0,            0, 0, 0), '0);
    add("rm_req",    1, iv(1, 0, 0,   0, 1, 0, 0, DC, 0,            1, 0, 0),
                        ov(1, 1, 0, 0, DC, 0, 0, 0, 0, 1, 0, 0));
    add("rm_rst",    1, iv(0, 0, 0,   0, 0, 0, 0, 0,  0,            0, 0, 0),
                        ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("rm_late",   1, iv(1, 0, 0,   0, 0, 0, 0, 0,  0,            0, 1, 32'hFF), '0);

    for (int k = 0; k < vecs.size(); k++) begin
      @(posedge clk); #1;
      apply(vecs[k].i);
      @(negedge clk);
      if (vecs[k].chk) check(vecs[k].name, vecs[k].o);
    end

    // Both requesters held continuously with an always-ready memory.
    @(posedge clk); #1;
    apply(iv(1, 1, IA0, 0, 1, 0, 0, DA, 0, 1, 1, 0));
    got_n = 0;
    for (int cyc = 0; cyc < 60 && got_n < 10; cyc++) begin
      @(negedge clk);
      if (inst_addr_ok || data_addr_ok) begin
        n_cmp++;
        if (inst_addr_ok !== exp_inst[got_n] || data_addr_ok !== !exp_inst[got_n]) begin
          n_bad++;
          $display("FAIL starve_grant%0d: inst_addr_ok=%b data_addr_ok=%b want inst=%b",
                   got_n, inst_addr_ok, data_addr_ok, exp_inst[got_n]);
        end
        got_n++;
      end
      @(posedge clk); #1;
    end
    if (got_n < 10) begin
      n_cmp++;
      n_bad++;
      $display("FAIL starve_timeout: got %0d grants want 10", got_n);
    end

    apply(iv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    t_vld = 0; t_inst = 0; t_acc = 0; t_drop = 0; t_wr = 0; t_wstrb = '0; t_addr = '0; t_wdata = '0;
    hist.delete();
    ih = 0; dh = 0; ia = '0; da = '0; dwd = '0; dw = 1'b0; dws = '0;

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (!ih && $urandom_range(0, 2) == 0) begin
        ih = 1;
        ia = $urandom() & 32'hFFFF_FFFC;
      end
      if (!dh && $urandom_range(0, 2) == 0) begin
        dh  = 1;
        da  = $urandom();
        dw  = 1'($urandom_range(0, 1));
        dws = dw ? 4'($urandom_range(1, 15)) : 4'h0;
        dwd = $urandom();
      end
      cancel = ($urandom_range(0, 7) == 0);
      maok   = 1'($urandom_range(0, 1));
      mdok   = 1'($urandom_range(0, 1));
      rd     = $urandom();
      rst = 1'b1; inst_req = ih; inst_addr = ia; inst_cancel = cancel;
      data_req = dh; data_wr = dw; data_wstrb = dws; data_addr = da; data_wdata = dwd;
      mem_addr_ok = maok; mem_data_ok = mdok; mem_rdata = rd;
      @(negedge clk);

      exp = '0;
      exp.busy = t_vld;
      exp.mreq = t_vld && !t_acc;
      if (exp.mreq) begin
        exp.mwr = t_wr; exp.mwstrb = t_wstrb; exp.maddr = t_addr; exp.mwdata = t_wdata;
        exp.iaok = t_inst && maok;
        exp.daok = !t_inst && maok;
      end
      if (t_vld && t_acc) begin
        if (t_inst) begin
          exp.irdata = rd;
          exp.idok   = mdok && !t_drop && !cancel;
        end else begin
          exp.drdata = rd;
          exp.ddok   = mdok;
        end
      end
      check($sformatf("rand%0d", c), exp);

      if (!t_vld) begin
        if (ih || dh) begin
          pick = ih && (!dh || fetch_starved());
          if (pick || dh && ih) hist.push_back(pick);
          if (hist.size() > 16) void'(hist.pop_front());
          t_vld = 1; t_acc = 0; t_drop = 0; t_inst = pick;
          t_addr  = pick ? ia : da;
          t_wr    = pick ? 1'b0 : dw;
          t_wstrb = pick ? 4'h0 : dws;
          t_wdata = pick ? 32'h0 : dwd;
        end
      end else if (!t_acc) begin
        if (t_inst && cancel && !maok) t_vld = 0;
        else if (maok) begin
          t_acc  = 1;
          t_drop = t_inst && cancel;
        end
      end else begin
        if (t_inst && cancel) t_drop = 1;
        if (mdok) t_vld = 0;
      end
      if (exp.iaok || cancel) ih = 0;
      if (exp.daok) dh = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
